// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared state encoding, coin values and default parameters for the vending block
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2,
        ST_DONE   = 2'd3
    } vend_state_e;

    localparam int NICKEL_VAL  = 5;
    localparam int DIME_VAL    = 10;
    localparam int QUARTER_VAL = 25;

    localparam int DEF_N_ITEMS    = 4;
    localparam int DEF_PRICE      = 15;
    localparam int DEF_MAX_CREDIT = 50;
    localparam int DEF_CREDIT_W   = 6;
    localparam int DEF_STOCK_W    = 4;
    localparam int DEF_INIT_STOCK = 8;

endpackage

// File: rtl/vend_stock.sv
// rtl/vend_stock.sv - per-item stock counters with registered sold-out flags
module vend_stock
    import vend_pkg::*;
#(
    parameter int N_ITEMS    = DEF_N_ITEMS,
    parameter int STOCK_W    = DEF_STOCK_W,
    parameter int INIT_STOCK = DEF_INIT_STOCK,
    localparam int SEL_W     = $clog2(N_ITEMS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         dec_en,
    input  logic [SEL_W-1:0]             dec_idx,
    input  logic                         reload,
    output logic [N_ITEMS*STOCK_W-1:0]   stock,
    output logic [N_ITEMS-1:0]           sold_out
);

    localparam logic [STOCK_W-1:0] INIT_VAL = STOCK_W'(INIT_STOCK);
    localparam logic [STOCK_W-1:0] ONE_VAL  = STOCK_W'(1);

    logic [N_ITEMS*STOCK_W-1:0] stock_q, stock_d;
    logic [N_ITEMS-1:0]         sold_out_q, sold_out_d;

    // Reload wins over a decrement; sold_out is derived from the next value so it stays registered.
    always_comb begin
        stock_d    = stock_q;
        sold_out_d = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (reload) begin
                stock_d[i*STOCK_W +: STOCK_W] = INIT_VAL;
            end else if (dec_en && (dec_idx == SEL_W'(i))
                         && (stock_q[i*STOCK_W +: STOCK_W] != '0)) begin
                stock_d[i*STOCK_W +: STOCK_W] = stock_q[i*STOCK_W +: STOCK_W] - ONE_VAL;
            end
            sold_out_d[i] = (stock_d[i*STOCK_W +: STOCK_W] == '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stock_q    <= {N_ITEMS{INIT_VAL}};
            sold_out_q <= {N_ITEMS{INIT_VAL == '0}};
        end else begin
            stock_q    <= stock_d;
            sold_out_q <= sold_out_d;
        end
    end

    assign stock    = stock_q;
    assign sold_out = sold_out_q;

endmodule

// File: rtl/param_vending.sv
// rtl/param_vending.sv - parameterised coin-operated vending controller with change and restock
module param_vending
    import vend_pkg::*;
#(
    parameter int N_ITEMS    = DEF_N_ITEMS,
    parameter int PRICE      = DEF_PRICE,
    parameter int MAX_CREDIT = DEF_MAX_CREDIT,
    parameter int CREDIT_W   = DEF_CREDIT_W,
    parameter int STOCK_W    = DEF_STOCK_W,
    parameter int INIT_STOCK = DEF_INIT_STOCK,
    localparam int SEL_W     = $clog2(N_ITEMS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                nickel,
    input  logic                dime,
    input  logic                quarter,
    input  logic [SEL_W-1:0]    sel,
    input  logic                dispense_in,
    input  logic                cancel,
    input  logic                restock,
    output logic                dispense_out,
    output logic [SEL_W-1:0]    item_out,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_out,
    output logic                done,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic [N_ITEMS-1:0]  sold_out,
    output logic                busy
);

    localparam int SUM_W = CREDIT_W + 1;
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [SUM_W-1:0]    MAX_C   = SUM_W'(MAX_CREDIT);

    vend_state_e state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic [SEL_W-1:0]    item_q, item_d;
    logic                dispense_q, dispense_d;
    logic                change_valid_q, change_valid_d;
    logic [CREDIT_W-1:0] change_out_q, change_out_d;
    logic                done_q, done_d;
    logic                reject_q, reject_d;
    logic                busy_q, busy_d;

    logic                       dec_en, reload;
    logic [N_ITEMS*STOCK_W-1:0] stock_flat;
    logic                       coin_any, coin_extra, sel_ok, item_avail;
    logic [SUM_W-1:0]           coin_val, credit_sum;

    vend_stock #(
        .N_ITEMS    (N_ITEMS),
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK)
    ) u_stock (
        .clk      (clk),
        .reset    (reset),
        .dec_en   (dec_en),
        .dec_idx  (sel),
        .reload   (reload),
        .stock    (stock_flat),
        .sold_out (sold_out)
    );

    assign coin_any   = nickel | dime | quarter;
    assign coin_extra = (quarter & (dime | nickel)) | (dime & nickel);
    assign coin_val   = quarter ? SUM_W'(QUARTER_VAL) :
                        dime    ? SUM_W'(DIME_VAL)    :
                        nickel  ? SUM_W'(NICKEL_VAL)  : '0;
    assign credit_sum = {1'b0, credit_q} + coin_val;
    assign sel_ok     = (int'(sel) < N_ITEMS);
    assign item_avail = sel_ok && (stock_flat[int'(sel)*STOCK_W +: STOCK_W] != '0);

    // Pulse outputs are computed from the transition and registered, so they line up with the new state.
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        change_d       = change_q;
        item_d         = item_q;
        dispense_d     = 1'b0;
        change_valid_d = 1'b0;
        change_out_d   = '0;
        done_d         = 1'b0;
        reject_d       = 1'b0;
        dec_en         = 1'b0;
        reload         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cancel && (credit_q != '0)) begin
                    state_d        = ST_CHANGE;
                    change_valid_d = 1'b1;
                    change_out_d   = credit_q;
                    credit_d       = '0;
                    reject_d       = coin_any;
                    reload         = restock;
                end else if (dispense_in && (credit_q >= PRICE_C) && item_avail) begin
                    state_d    = ST_VEND;
                    dispense_d = 1'b1;
                    item_d     = sel;
                    dec_en     = 1'b1;
                    change_d   = credit_q - PRICE_C;
                    credit_d   = '0;
                    reject_d   = coin_any;
                end else begin
                    reload = restock;
                    if (coin_any) begin
                        if (credit_sum > MAX_C) begin
                            reject_d = 1'b1;
                        end else begin
                            credit_d = credit_sum[CREDIT_W-1:0];
                            reject_d = coin_extra;
                        end
                    end
                end
            end
            ST_VEND: begin
                reject_d = coin_any;
                if (change_q != '0) begin
                    state_d        = ST_CHANGE;
                    change_valid_d = 1'b1;
                    change_out_d   = change_q;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_CHANGE: begin
                reject_d = coin_any;
                state_d  = ST_DONE;
                change_d = '0;
                done_d   = 1'b1;
            end
            ST_DONE: begin
                reject_d = coin_any;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            credit_q       <= '0;
            change_q       <= '0;
            item_q         <= '0;
            dispense_q     <= 1'b0;
            change_valid_q <= 1'b0;
            change_out_q   <= '0;
            done_q         <= 1'b0;
            reject_q       <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            change_q       <= change_d;
            item_q         <= item_d;
            dispense_q     <= dispense_d;
            change_valid_q <= change_valid_d;
            change_out_q   <= change_out_d;
            done_q         <= done_d;
            reject_q       <= reject_d;
            busy_q         <= busy_d;
        end
    end

    assign dispense_out = dispense_q;
    assign item_out     = item_q;
    assign change_valid = change_valid_q;
    assign change_out   = change_out_q;
    assign done         = done_q;
    assign coin_reject  = reject_q;
    assign credit       = credit_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_param_vending.sv
// tb/tb_param_vending.sv - directed self-checking bench for param_vending
module tb_param_vending;

    logic       clk = 1'b0;
    logic       reset;
    logic       nickel, dime, quarter;
    logic [1:0] sel;
    logic       dispense_in, cancel, restock;
    logic       dispense_out;
    logic [1:0] item_out;
    logic       change_valid;
    logic [5:0] change_out;
    logic       done, coin_reject;
    logic [5:0] credit;
    logic [3:0] sold_out;
    logic       busy;

    int tests  = 0;
    int failed = 0;

    param_vending dut (
        .clk          (clk),
        .reset        (reset),
        .nickel       (nickel),
        .dime         (dime),
        .quarter      (quarter),
        .sel          (sel),
        .dispense_in  (dispense_in),
        .cancel       (cancel),
        .restock      (restock),
        .dispense_out (dispense_out),
        .item_out     (item_out),
        .change_valid (change_valid),
        .change_out   (change_out),
        .done         (done),
        .coin_reject  (coin_reject),
        .credit       (credit),
        .sold_out     (sold_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        nickel = 0; dime = 0; quarter = 0; sel = 0;
        dispense_in = 0; cancel = 0; restock = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    function automatic logic [3:0] stock_of(input int idx);
        logic [15:0] flat;
        flat = dut.stock_flat;
        return flat[idx*4 +: 4];
    endfunction

    task automatic test_reset();
        clear_inputs();
        reset = 0;
        #12;
        tests++; if (credit !== 6'd0 || busy !== 1'b0) begin failed++; $display("FAIL reset_state: credit=%0d busy=%0d expected 0/0", credit, busy); end
        tests++; if ({dispense_out, change_valid, done, coin_reject} !== 4'b0 || change_out !== 6'd0 || item_out !== 2'd0) begin failed++; $display("FAIL reset_outputs: pulses=%b change_out=%0d item_out=%0d expected 0", {dispense_out, change_valid, done, coin_reject}, change_out, item_out); end
        tests++; if (sold_out !== 4'b0000) begin failed++; $display("FAIL reset_sold_out: got %b expected 0000", sold_out); end
        @(negedge clk);
        reset = 1;
        #1;
    endtask

    task automatic test_exact_vend();
        nickel = 1; tick();
        dime = 1; tick();
        tests++; if (credit !== 6'd15) begin failed++; $display("FAIL exact_credit: got %0d expected 15", credit); end
        dispense_in = 1; sel = 2; tick();
        tests++; if (dispense_out !== 1'b1 || item_out !== 2'd2 || busy !== 1'b1) begin failed++; $display("FAIL exact_dispense: disp=%0d item=%0d busy=%0d expected 1/2/1", dispense_out, item_out, busy); end
        tick();
        tests++; if (done !== 1'b1 || change_valid !== 1'b0 || dispense_out !== 1'b0) begin failed++; $display("FAIL exact_done: done=%0d cv=%0d disp=%0d expected 1/0/0", done, change_valid, dispense_out); end
        tests++; if (stock_of(2) !== 4'd7) begin failed++; $display("FAIL exact_stock2: got %0d expected 7", stock_of(2)); end
        tick();
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin failed++; $display("FAIL exact_idle: busy=%0d done=%0d expected 0/0", busy, done); end
    endtask

    task automatic test_change();
        quarter = 1; tick();
        dispense_in = 1; sel = 0; tick();
        tests++; if (dispense_out !== 1'b1 || item_out !== 2'd0) begin failed++; $display("FAIL change_dispense: disp=%0d item=%0d expected 1/0", dispense_out, item_out); end
        nickel = 1; tick();
        tests++; if (change_valid !== 1'b1 || change_out !== 6'd10) begin failed++; $display("FAIL change_value: cv=%0d out=%0d expected 1/10", change_valid, change_out); end
        tests++; if (coin_reject !== 1'b1) begin failed++; $display("FAIL change_busy_reject: got %0d expected 1", coin_reject); end
        tick();
        tests++; if (done !== 1'b1 || change_valid !== 1'b0 || change_out !== 6'd0) begin failed++; $display("FAIL change_done: done=%0d cv=%0d out=%0d expected 1/0/0", done, change_valid, change_out); end
        tick();
        tests++; if (credit !== 6'd0 || busy !== 1'b0) begin failed++; $display("FAIL change_credit: credit=%0d busy=%0d expected 0/0", credit, busy); end
    endtask

    task automatic test_ceiling();
        quarter = 1; tick();
        quarter = 1; tick();
        tests++; if (credit !== 6'd50) begin failed++; $display("FAIL ceiling_credit: got %0d expected 50", credit); end
        dime = 1; tick();
        tests++; if (coin_reject !== 1'b1 || credit !== 6'd50) begin failed++; $display("FAIL ceiling_reject: rej=%0d credit=%0d expected 1/50", coin_reject, credit); end
        tick();
        tests++; if (coin_reject !== 1'b0) begin failed++; $display("FAIL ceiling_pulse: got %0d expected 0", coin_reject); end
        cancel = 1; tick();
        tests++; if (change_valid !== 1'b1 || change_out !== 6'd50 || credit !== 6'd0) begin failed++; $display("FAIL ceiling_refund: cv=%0d out=%0d credit=%0d expected 1/50/0", change_valid, change_out, credit); end
        tick();
        tests++; if (done !== 1'b1) begin failed++; $display("FAIL ceiling_done: got %0d expected 1", done); end
        tick();
    endtask

    task automatic test_multi_coin();
        dime = 1; nickel = 1; tick();
        tests++; if (credit !== 6'd10 || coin_reject !== 1'b1) begin failed++; $display("FAIL multi_coin: credit=%0d rej=%0d expected 10/1", credit, coin_reject); end
        dispense_in = 1; sel = 3; tick();
        tests++; if (busy !== 1'b0 || dispense_out !== 1'b0 || credit !== 6'd10) begin failed++; $display("FAIL multi_low_credit: busy=%0d disp=%0d credit=%0d expected 0/0/10", busy, dispense_out, credit); end
        cancel = 1; tick();
        tests++; if (change_out !== 6'd10) begin failed++; $display("FAIL multi_refund: got %0d expected 10", change_out); end
        tick(); tick();
    endtask

    task automatic test_sold_out();
        for (int k = 0; k < 8; k++) begin
            dime = 1; tick();
            nickel = 1; tick();
            dispense_in = 1; sel = 1; tick();
            tick(); tick();
        end
        tests++; if (sold_out !== 4'b0010 || stock_of(1) !== 4'd0) begin failed++; $display("FAIL sold_out_set: sold=%b stock1=%0d expected 0010/0", sold_out, stock_of(1)); end
        dime = 1; tick();
        nickel = 1; tick();
        dispense_in = 1; sel = 1; tick();
        tests++; if (busy !== 1'b0 || dispense_out !== 1'b0 || credit !== 6'd15) begin failed++; $display("FAIL sold_out_ignore: busy=%0d disp=%0d credit=%0d expected 0/0/15", busy, dispense_out, credit); end
        restock = 1; tick();
        tests++; if (sold_out !== 4'b0000 || stock_of(1) !== 4'd8) begin failed++; $display("FAIL restock: sold=%b stock1=%0d expected 0000/8", sold_out, stock_of(1)); end
        cancel = 1; tick(); tick(); tick();
    endtask

    task automatic test_reset_mid_vend();
        int cv_seen;
        quarter = 1; tick();
        dispense_in = 1; sel = 3; tick();
        tests++; if (dispense_out !== 1'b1) begin failed++; $display("FAIL mid_vend_entry: got %0d expected 1", dispense_out); end
        reset = 0;
        #1;
        tests++; if (busy !== 1'b0 || credit !== 6'd0 || dispense_out !== 1'b0) begin failed++; $display("FAIL mid_vend_reset: busy=%0d credit=%0d disp=%0d expected 0/0/0", busy, credit, dispense_out); end
        tests++; if (stock_of(0) !== 4'd8 || stock_of(1) !== 4'd8 || stock_of(2) !== 4'd8 || stock_of(3) !== 4'd8) begin failed++; $display("FAIL mid_vend_stock: %0d %0d %0d %0d expected 8 8 8 8", stock_of(0), stock_of(1), stock_of(2), stock_of(3)); end
        @(negedge clk);
        reset = 1;
        cv_seen = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (change_valid !== 1'b0) cv_seen++;
        end
        tests++; if (cv_seen != 0) begin failed++; $display("FAIL mid_vend_no_change: change_valid high %0d cycles expected 0", cv_seen); end
    endtask

    task automatic test_first_coin();
        reset = 0;
        #3;
        @(negedge clk);
        reset = 1;
        nickel = 1; tick();
        tests++; if (credit !== 6'd5 || coin_reject !== 1'b0) begin failed++; $display("FAIL first_coin: credit=%0d rej=%0d expected 5/0", credit, coin_reject); end
        cancel = 1; tick();
        tests++; if (change_valid !== 1'b1 || change_out !== 6'd5) begin failed++; $display("FAIL first_coin_refund: cv=%0d out=%0d expected 1/5", change_valid, change_out); end
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_exact_vend();
        test_change();
        test_ceiling();
        test_multi_coin();
        test_sold_out();
        test_reset_mid_vend();
        test_first_coin();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
